slave_fifo: RTL and testbench
=============================

SLAVE_FIFO -- requirements
Module: slave_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 Parameter IDLE_VALUE, default {WIDTH{1'b1}}, value driven on m_data_out when no entry is present.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  sink enable; registered one cycle before it affects s_ready.
REQ-007 flush  input  1  synchronous discard of all buffered entries.
REQ-008 s_valid  input  1  upstream data valid.
REQ-009 s_data_in  input  WIDTH  upstream data.
REQ-010 s_ready  output  1  sink can accept this cycle.
REQ-011 m_valid  output  1  buffer non-empty; head entry presented.
REQ-012 m_ready  input  1  downstream accepts head entry.
REQ-013 m_data_out  output  WIDTH  head entry, or IDLE_VALUE when empty.
REQ-014 count  output  $clog2(DEPTH+1)  number of entries held, 0..DEPTH.
REQ-015 drop  output  1  one-cycle pulse: s_valid high while s_ready low.

Function
REQ-016 en_q SHALL be a register loaded with en each cycle; s_ready SHALL equal en_q AND (count != DEPTH) AND NOT flush.
REQ-017 Push SHALL occur when s_valid && s_ready: s_data_in written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 m_valid SHALL equal (count != 0); m_data_out SHALL equal mem[rd_ptr] when m_valid, else IDLE_VALUE.
REQ-019 Pop SHALL occur when m_valid && m_ready && !flush: rd_ptr increments modulo DEPTH.
REQ-020 Latency: a word pushed at edge N SHALL appear on m_data_out after edge N (visible in cycle N+1) if the buffer was empty; no combinational s_data_in -> m_data_out path.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-022 Full (count == DEPTH): s_ready low; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-023 Empty (count == 0): pop SHALL be impossible; m_ready ignored.
REQ-024 Order SHALL be strict FIFO; no entry lost or duplicated across pointer wrap-around.
REQ-025 flush high SHALL, at the next edge, set count, wr_ptr, rd_ptr to 0; push and pop inhibited in that cycle; en_q updates normally.
REQ-026 drop SHALL be registered: set for one cycle after any edge where s_valid && !s_ready, else 0.
REQ-027 Storage contents need not be cleared by reset or flush; only pointers/count are.

Reset
REQ-028 rst high at an edge SHALL set en_q=0, wr_ptr=0, rd_ptr=0, count=0, drop=0; rst overrides flush, push and pop.
REQ-029 After reset: s_ready=0, m_valid=0, m_data_out=IDLE_VALUE, count=0 until en is sampled high.
REQ-030 Reset asserted mid-transfer SHALL discard all held entries; no pop occurs in the reset cycle.

Verification
REQ-031 Reset release, en=1 from cycle 0 -> s_ready=0 in cycle 0, s_ready=1 from cycle 1; m_data_out=8'hFF while empty.
REQ-032 DEPTH=4, m_ready=0, push 8'h11,22,33,44,55 back-to-back -> count reaches 4, s_ready drops after 4th push, 8'h55 not accepted, drop pulses one cycle per rejected beat.
REQ-033 Full buffer, then m_ready=1 and s_valid=1 constant -> 11,22,33,44 drained in order; s_ready reasserts the cycle after first pop; 8'h55 then accepted and emerges fifth.
REQ-034 Continuous push and pop for 10 words (8'h00..8'h09) with count=1 -> count stays 1, output order 00..09 across two pointer wraps.
REQ-035 Three entries held, flush pulsed one cycle with s_valid=1, m_ready=1 -> next cycle count=0, m_valid=0, m_data_out=IDLE_VALUE, no push/pop in flush cycle.
REQ-036 Two entries held, rst pulsed with m_ready=1 -> count=0, s_ready=0 next cycle, s_ready=1 one cycle after rst falls with en=1.

Source files
------------

// File: rtl/slave_fifo_if.sv
// ---------------------------------------------------------------------------
// slave_fifo_if
// Handshake bundle for the slave_fifo buffer.
//   s_valid    : upstream word valid          (producer -> fifo)
//   s_data_in  : upstream word                (producer -> fifo)
//   s_ready    : fifo can accept this cycle   (fifo -> producer)
//   m_valid    : fifo presents a head entry   (fifo -> consumer)
//   m_data_out : head entry or idle pattern   (fifo -> consumer)
//   m_ready    : consumer takes head entry    (consumer -> fifo)
// Modport slave is the fifo's view; modport master is the environment's view.
// ---------------------------------------------------------------------------
interface slave_fifo_if #(
   parameter int unsigned WIDTH = 8
);
   logic             s_valid;
   logic [WIDTH-1:0] s_data_in;
   logic             s_ready;
   logic             m_valid;
   logic [WIDTH-1:0] m_data_out;
   logic             m_ready;

   modport slave (
      input  s_valid, s_data_in, m_ready,
      output s_ready, m_valid, m_data_out
   );

   modport master (
      output s_valid, s_data_in, m_ready,
      input  s_ready, m_valid, m_data_out
   );
endinterface

// File: rtl/slave_fifo.sv
// ---------------------------------------------------------------------------
// slave_fifo
// Small circular buffer with valid/ready handshakes on both sides.
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset (pointers, count, enable, drop)
//   en     : sink enable, registered before it gates s_ready
//   flush  : synchronous discard of all held entries
//   bus    : slave_fifo_if.slave handshake bundle
//   count  : number of entries held, 0..DEPTH
//   drop   : registered pulse, upstream offered a word while not ready
// ---------------------------------------------------------------------------
module slave_fifo #(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      DEPTH      = 4,
   parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b1}}
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   slave_fifo_if.slave                bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic          en_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          drop_q,   drop_d;

   logic s_ready;
   logic m_valid;
   logic push;
   logic pop;

   // Readiness looks only at the current count, so a pop while full never
   // opens a slot for a same-cycle push.
   always_comb begin
      s_ready = en_q && (count_q != CW'(DEPTH)) && !flush;
      m_valid = (count_q != '0);
      push    = bus.s_valid && s_ready;
      pop     = m_valid && bus.m_ready && !flush;
      drop_d  = bus.s_valid && !s_ready;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of its peers.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         en_q     <= en;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // NOTE: storage has no reset; stale words are unreachable once the
   // pointers and count are cleared, and leaving it unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr_q] <= bus.s_data_in;
   end

   assign bus.s_ready    = s_ready;
   assign bus.m_valid    = m_valid;
   assign bus.m_data_out = m_valid ? mem[rd_ptr_q] : IDLE_VALUE;
   assign count          = count_q;
   assign drop           = drop_q;

endmodule

// File: tb/tb_slave_fifo.sv
// ---------------------------------------------------------------------------
// tb_slave_fifo
// Directed bench for slave_fifo (WIDTH=8, DEPTH=4, IDLE_VALUE=8'hFF).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_slave_fifo;

   logic       clk;
   logic       rst;
   logic       en;
   logic       flush;
   logic [2:0] count;
   logic       drop;

   int checks   = 0;
   int failures = 0;

   slave_fifo_if #(.WIDTH(8)) bus ();

   slave_fifo #(.WIDTH(8), .DEPTH(4), .IDLE_VALUE(8'hFF)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .bus   (bus),
      .count (count),
      .drop  (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start of one clock cycle: apply inputs just after the edge, then settle.
   task automatic cyc(input logic r, input logic e, input logic fl,
                      input logic sv, input logic [7:0] d, input logic mr);
      @(posedge clk);
      #1;
      rst           = r;
      en            = e;
      flush         = fl;
      bus.s_valid   = sv;
      bus.s_data_in = d;
      bus.m_ready   = mr;
      #2;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; flush = 1'b0;
      bus.s_valid = 1'b0; bus.s_data_in = '0; bus.m_ready = 1'b0;

      cyc(1, 0, 0, 0, 8'h00, 0);
      cyc(1, 1, 0, 0, 8'h00, 0);

      // Reset release with en already high
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("rst_s_ready",  bus.s_ready,    0);
      check("rst_m_valid",  bus.m_valid,    0);
      check("rst_idle",     bus.m_data_out, 8'hFF);
      check("rst_count",    count,          0);
      check("rst_drop",     drop,           0);

      // Fill to full, overflow with 8'h55
      cyc(0, 1, 0, 1, 8'h11, 0);
      check("c1_s_ready",   bus.s_ready,    1);
      check("c1_count",     count,          0);
      cyc(0, 1, 0, 1, 8'h22, 0);
      check("lat_m_valid",  bus.m_valid,    1);
      check("lat_data",     bus.m_data_out, 8'h11);
      check("fill_cnt1",    count,          1);
      cyc(0, 1, 0, 1, 8'h33, 0);
      check("fill_cnt2",    count,          2);
      cyc(0, 1, 0, 1, 8'h44, 0);
      check("fill_cnt3",    count,          3);
      check("fill_rdy3",    bus.s_ready,    1);
      cyc(0, 1, 0, 1, 8'h55, 0);
      check("full_count",   count,          4);
      check("full_s_ready", bus.s_ready,    0);
      check("full_drop0",   drop,           0);
      check("full_head",    bus.m_data_out, 8'h11);
      cyc(0, 1, 0, 1, 8'h55, 0);
      check("drop_1st",     drop,           1);
      check("full_count2",  count,          4);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("drop_2nd",     drop,           1);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("drop_clear",   drop,           0);
      check("full_count3",  count,          4);

      // Drain from full with upstream still offering 8'h55
      cyc(0, 1, 0, 1, 8'h55, 1);
      check("drn_rdy_full", bus.s_ready,    0);
      check("drn_d0",       bus.m_data_out, 8'h11);
      check("drn_c0",       count,          4);
      check("drn_drop0",    drop,           0);
      cyc(0, 1, 0, 1, 8'h55, 1);
      check("drn_rdy_back", bus.s_ready,    1);
      check("drn_d1",       bus.m_data_out, 8'h22);
      check("drn_c1",       count,          3);
      check("drn_drop1",    drop,           1);
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("drn_d2",       bus.m_data_out, 8'h33);
      check("drn_c2",       count,          3);
      check("drn_drop2",    drop,           0);
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("drn_d3",       bus.m_data_out, 8'h44);
      check("drn_c3",       count,          2);
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("drn_d4",       bus.m_data_out, 8'h55);
      check("drn_c4",       count,          1);
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("drn_empty_v",  bus.m_valid,    0);
      check("drn_empty_d",  bus.m_data_out, 8'hFF);
      check("drn_empty_c",  count,          0);

      // Streaming 00..09 at occupancy one, across pointer wraps
      cyc(0, 1, 0, 1, 8'h00, 1);
      check("str_c_start",  count,          0);
      for (int i = 1; i < 10; i++) begin
         cyc(0, 1, 0, 1, 8'(i), 1);
         check($sformatf("str_d%0d", i - 1), bus.m_data_out, 32'(i - 1));
         check($sformatf("str_c%0d", i - 1), count,          1);
      end
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("str_d9",       bus.m_data_out, 8'h09);
      check("str_c9",       count,          1);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("str_end_c",    count,          0);
      check("str_end_v",    bus.m_valid,    0);

      // Flush with three entries held
      cyc(0, 1, 0, 1, 8'hAA, 0);
      cyc(0, 1, 0, 1, 8'hBB, 0);
      cyc(0, 1, 0, 1, 8'hCC, 0);
      cyc(0, 1, 1, 1, 8'hDD, 1);
      check("fl_pre_count", count,          3);
      check("fl_s_ready",   bus.s_ready,    0);
      check("fl_pre_head",  bus.m_data_out, 8'hAA);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("fl_count",     count,          0);
      check("fl_m_valid",   bus.m_valid,    0);
      check("fl_idle",      bus.m_data_out, 8'hFF);
      check("fl_drop",      drop,           1);
      check("fl_rdy_after", bus.s_ready,    1);
      cyc(0, 1, 0, 1, 8'hEE, 0);
      check("fl_no_push",   count,          0);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("fl_new_data",  bus.m_data_out, 8'hEE);
      check("fl_new_count", count,          1);
      cyc(0, 1, 0, 0, 8'h00, 1);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("fl_drained",   count,          0);

      // en is registered before gating s_ready
      cyc(0, 0, 0, 0, 8'h00, 0);
      check("en_lag_hi",    bus.s_ready,    1);
      cyc(0, 0, 0, 0, 8'h00, 0);
      check("en_off",       bus.s_ready,    0);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("en_lag_lo",    bus.s_ready,    0);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("en_on",        bus.s_ready,    1);

      // Reset mid-transfer with two entries held
      cyc(0, 1, 0, 1, 8'h01, 0);
      cyc(0, 1, 0, 1, 8'h02, 0);
      cyc(1, 1, 0, 0, 8'h00, 1);
      check("mr_pre_count", count,          2);
      check("mr_pre_head",  bus.m_data_out, 8'h01);
      cyc(0, 1, 0, 0, 8'h00, 1);
      check("mr_count",     count,          0);
      check("mr_s_ready",   bus.s_ready,    0);
      check("mr_m_valid",   bus.m_valid,    0);
      check("mr_idle",      bus.m_data_out, 8'hFF);
      check("mr_drop",      drop,           0);
      cyc(0, 1, 0, 0, 8'h00, 0);
      check("mr_rdy_back",  bus.s_ready,    1);
      check("mr_count2",    count,          0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
